// File: rtl/mem_sp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_sp_ctrl
//  Description : Byte-addressed single-port data memory with a valid/ready
//                request port, per-byte write enables, registered big-endian
//                word reads, range flagging and a hardware clear engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_sp_ctrl #(
    parameter int MEM_DEPTH      = 2048,
    parameter int WORD_BYTES     = 2,
    parameter int ADDR_WIDTH     = 16,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [WORD_BYTES-1:0]   req_be,
    input  logic [8*WORD_BYTES-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [8*WORD_BYTES-1:0] rsp_rdata,
    output logic                    rsp_err,
    input  logic                    clear_start,
    output logic                    clear_busy
);

    localparam int c_data_w = 8 * WORD_BYTES;
    localparam int c_idx_w  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int c_words  = MEM_DEPTH / WORD_BYTES;
    localparam int c_cnt_w  = (c_words > 1) ? $clog2(c_words) : 1;

    localparam logic [ADDR_WIDTH:0] c_max_addr  = (ADDR_WIDTH+1)'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] c_span      = (ADDR_WIDTH+1)'(WORD_BYTES - 1);
    localparam logic [c_cnt_w-1:0]  c_last_word = c_cnt_w'(c_words - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t c_reset_state = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    logic [7:0]          r_mem [MEM_DEPTH];
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  r_clr_cnt;
    logic                w_accept;
    logic                w_range_err;
    logic                w_clr_active;
    logic                w_clr_last;
    logic [ADDR_WIDTH:0] w_last_addr;
    logic [c_idx_w-1:0]  w_base_idx;
    logic [c_idx_w-1:0]  w_clr_base;
    logic [c_data_w-1:0] w_rd_word;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_reset_state;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        clear_busy  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (clear_start) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clear_busy = 1'b1;
                if (w_clr_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Clear engine word counter
    // ------------------------------------------------------------------------
    assign w_clr_last   = (r_clr_cnt == c_last_word);
    // Reset must never disturb the array, even while the FSM sits in CLEAR.
    assign w_clr_active = (r_state == ST_CLEAR) && !reset;
    assign w_clr_base   = c_idx_w'(r_clr_cnt) * c_idx_w'(WORD_BYTES);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + 1'b1;
        end else begin
            r_clr_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Request decode and range check (one extra bit so the end never wraps)
    // ------------------------------------------------------------------------
    assign w_accept    = req_valid & req_ready;
    assign w_last_addr = {1'b0, req_addr} + c_span;
    assign w_range_err = (w_last_addr > c_max_addr);
    assign w_base_idx  = req_addr[c_idx_w-1:0];

    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            w_rd_word[8*(WORD_BYTES-k)-1 -: 8] = r_mem[w_base_idx + c_idx_w'(k)];
        end
    end

    // ------------------------------------------------------------------------
    // Storage array: clear engine has priority (requests are blocked then)
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_clr_active) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                r_mem[w_clr_base + c_idx_w'(k)] <= 8'h00;
            end
        end else if (w_accept && req_wr && !w_range_err) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (req_be[WORD_BYTES-1-k]) begin
                    r_mem[w_base_idx + c_idx_w'(k)] <= req_wdata[8*(WORD_BYTES-k)-1 -: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= w_accept;
            rsp_err   <= w_accept & w_range_err;
            rsp_rdata <= (w_accept && !req_wr && !w_range_err) ? w_rd_word : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_sp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_sp_ctrl
//  Description : Self-checking bench for mem_sp_ctrl using a byte-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_sp_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_wr, clear_start;
    logic [15:0] req_addr, req_wdata;
    logic [1:0]  req_be;
    logic        req_ready, rsp_valid, rsp_err, clear_busy;
    logic [15:0] rsp_rdata;

    logic        b_reset, b_valid, b_wr, b_cs;
    logic [15:0] b_addr, b_wdata;
    logic [1:0]  b_be;
    logic        b_ready, b_rsp_valid, b_rsp_err, b_busy;
    logic [15:0] b_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] model_mem [0:2047];

    always #5 clock = ~clock;

    mem_sp_ctrl #(.MEM_DEPTH(2048), .WORD_BYTES(2), .ADDR_WIDTH(16), .CLEAR_ON_RESET(1)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .clear_start(clear_start), .clear_busy(clear_busy)
    );

    mem_sp_ctrl #(.MEM_DEPTH(2048), .WORD_BYTES(2), .ADDR_WIDTH(16), .CLEAR_ON_RESET(0)) dut_b (
        .clock(clock), .reset(b_reset), .req_valid(b_valid), .req_ready(b_ready),
        .req_wr(b_wr), .req_addr(b_addr), .req_be(b_be), .req_wdata(b_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_rsp_err),
        .clear_start(b_cs), .clear_busy(b_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2048; i++) model_mem[i] = 8'h00;
    endtask

    // One clock of stimulus on the main DUT; response checked after the edge.
    task automatic cycle(input bit v, input bit wr, input logic [15:0] addr,
                         input logic [1:0] be, input logic [15:0] wd, input bit cs);
        logic [15:0] exp_d;
        bit          exp_e;
        int          a;
        @(negedge clock);
        req_valid   = v;
        req_wr      = wr;
        req_addr    = addr;
        req_be      = be;
        req_wdata   = wd;
        clear_start = cs;
        check_eq("req_ready", req_ready, 1);
        exp_d = 16'h0000;
        exp_e = 1'b0;
        a     = addr;
        if (v) begin
            if (a + 1 > 2047) begin
                exp_e = 1'b1;
            end else if (wr) begin
                if (be[1]) model_mem[a]     = wd[15:8];
                if (be[0]) model_mem[a + 1] = wd[7:0];
            end else begin
                exp_d = {model_mem[a], model_mem[a + 1]};
            end
        end
        @(posedge clock);
        #1;
        req_valid   = 1'b0;
        clear_start = 1'b0;
        check_eq("rsp_valid", rsp_valid, v);
        check_eq("rsp_err", rsp_err, exp_e);
        check_eq("rsp_rdata", rsp_rdata, exp_d);
    endtask

    // Called at a negedge; counts clock cycles for which clear_busy stays high.
    task automatic count_busy(output int n, output int bad);
        n   = 0;
        bad = 0;
        while (clear_busy === 1'b1 && n < 2000) begin
            n++;
            if (req_ready !== 1'b0) bad++;
            @(negedge clock);
        end
    endtask

    initial begin
        int n, bad, sel;
        logic [15:0] addr;

        reset = 1'b1; req_valid = 0; req_wr = 0; req_addr = 0; req_be = 0;
        req_wdata = 0; clear_start = 0;
        b_reset = 1'b1; b_valid = 0; b_wr = 0; b_addr = 0; b_be = 0; b_wdata = 0; b_cs = 0;
        repeat (3) @(negedge clock);

        // Reset state
        check_eq("rst_busy", clear_busy, 1);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_valid", rsp_valid, 0);
        check_eq("rst_err", rsp_err, 0);
        check_eq("rst_rdata", rsp_rdata, 0);
        check_eq("b_rst_ready", b_ready, 1);
        check_eq("b_rst_busy", b_busy, 0);

        // Power-on clear duration
        reset   = 1'b0;
        b_reset = 1'b0;
        count_busy(n, bad);
        check_eq("por_clear_len", n, 1024);
        check_eq("por_ready_while_busy", bad, 0);
        model_clear();
        cycle(1, 0, 16'h07FE, 2'b00, 16'h0000, 0);
        check_eq("t1_rd_7fe", rsp_rdata, 16'h0000);

        // Full-word write and read-after-write
        cycle(1, 1, 16'h0010, 2'b11, 16'hA55A, 0);
        cycle(1, 0, 16'h0010, 2'b00, 16'h0000, 0);
        check_eq("t2_rd_10", rsp_rdata, 16'hA55A);
        cycle(1, 0, 16'h0011, 2'b00, 16'h0000, 0);
        check_eq("t2_rd_11", rsp_rdata, 16'h5A00);

        // Byte-enable merging
        cycle(1, 1, 16'h0020, 2'b10, 16'hBEEF, 0);
        cycle(1, 1, 16'h0020, 2'b01, 16'h1234, 0);
        cycle(1, 0, 16'h0020, 2'b00, 16'h0000, 0);
        check_eq("t3_rd_20", rsp_rdata, 16'hBE34);

        // Out-of-range accesses at the top of memory
        cycle(1, 0, 16'h07FF, 2'b00, 16'h0000, 0);
        check_eq("t4_rd_err", rsp_err, 1);
        cycle(1, 1, 16'h07FF, 2'b11, 16'hFFFF, 0);
        check_eq("t4_wr_err", rsp_err, 1);
        cycle(1, 0, 16'h07FE, 2'b00, 16'h0000, 0);
        check_eq("t4_rd_7fe", rsp_rdata, 16'h0000);

        // Write accepted together with clear_start
        cycle(1, 1, 16'h0040, 2'b11, 16'hCAFE, 1);
        @(negedge clock);
        count_busy(n, bad);
        check_eq("t5_clear_len", n, 1024);
        check_eq("t5_ready_while_busy", bad, 0);
        model_clear();
        cycle(1, 0, 16'h0040, 2'b00, 16'h0000, 0);
        check_eq("t5_rd_40", rsp_rdata, 16'h0000);

        // Reset in the middle of a clear restarts it
        cycle(0, 0, 16'h0000, 2'b00, 16'h0000, 1);
        repeat (500) @(negedge clock);
        check_eq("t6_mid_busy", clear_busy, 1);
        reset = 1'b1;
        #1;
        check_eq("t6_rst_busy", clear_busy, 1);
        check_eq("t6_rst_ready", req_ready, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        count_busy(n, bad);
        check_eq("t6_restart_len", n, 1024);
        model_clear();

        // Randomized traffic against the byte model
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)       addr = 16'($urandom_range(0, 31));
            else if (sel < 8)  addr = 16'($urandom_range(16'h07F8, 16'h07FF));
            else if (sel == 8) addr = 16'($urandom_range(16'h0800, 16'hFFFF));
            else               addr = 16'hFFFF;
            cycle(($urandom_range(0, 3) != 0), 1'($urandom), addr,
                  2'($urandom), 16'($urandom), 0);
        end

        // CLEAR_ON_RESET=0: reset mid-clear leaves partial contents, ready at once
        @(negedge clock);
        b_valid = 1; b_wr = 1; b_addr = 16'h0010; b_be = 2'b11; b_wdata = 16'h1111;
        @(posedge clock); #1;
        check_eq("b_wr_ack0", b_rsp_valid, 1);
        @(negedge clock);
        b_addr = 16'h0700; b_wdata = 16'h2222;
        @(posedge clock); #1;
        check_eq("b_wr_ack1", b_rsp_valid, 1);
        @(negedge clock);
        b_valid = 0; b_cs = 1;
        @(negedge clock);
        b_cs = 0;
        check_eq("b_busy", b_busy, 1);
        repeat (500) @(negedge clock);
        b_reset = 1'b1;
        #1;
        check_eq("b_rst_busy2", b_busy, 0);
        check_eq("b_rst_ready2", b_ready, 1);
        @(negedge clock);
        b_reset = 1'b0;
        check_eq("b_ready_after_rst", b_ready, 1);
        @(negedge clock);
        b_valid = 1; b_wr = 0; b_addr = 16'h0010;
        @(posedge clock); #1;
        check_eq("b_rd_cleared", b_rdata, 16'h0000);
        @(negedge clock);
        b_addr = 16'h0700;
        @(posedge clock); #1;
        check_eq("b_rd_kept", b_rdata, 16'h2222);
        b_valid = 0;
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
